slot_token_sched: RTL and testbench

Time-slot and token-bucket scheduler in front of the ESW ingress. It runs the slot clock from `time_slot_period` and meters the 134-bit packet stream leaving the beacon-update path against a per-slot token budget from `token_bucket_para`. Each packet is passed or dropped whole, and the decision is made at the packet head. New configuration is signalled by a `beacon_update_master` toggle and takes effect only at a slot boundary.

---
 rtl/slot_token_sched.sv | 169 ++++++++++++++++
 tb/tb_slot_token_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/slot_token_sched.sv
// slot_token_sched: slot timer plus token-bucket packet gate in front of the ESW ingress.
// Packets are passed or dropped whole, decided at the head word. New slot and refill
// settings are captured on a beacon toggle and take effect at the next slot boundary.
module slot_token_sched #(
    parameter logic [15:0] BUCKET_DEPTH = 16'd64,
    parameter logic [31:0] DEF_PERIOD   = 32'h7a12,
    parameter logic [31:0] DEF_REFILL   = 32'd10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  time_slot_period,
    input  logic [31:0]  token_bucket_para,
    input  logic         beacon_update_master,
    input  logic [133:0] in_data,
    input  logic         in_data_wr,
    input  logic         in_valid,
    input  logic         in_valid_wr,
    output logic [133:0] out_data,
    output logic         out_data_wr,
    output logic         out_valid,
    output logic         out_valid_wr,
    output logic         slot_start,
    output logic [7:0]   slot_id,
    output logic [15:0]  tokens,
    output logic [31:0]  pass_cnt,
    output logic [31:0]  drop_cnt
);

    localparam int unsigned DW = 134;
    localparam int unsigned CW = 32;
    localparam int unsigned TW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   slot_cnt_q;
    logic [CW-1:0]   active_period_q;
    logic [CW-1:0]   active_refill_q;
    logic [CW-1:0]   shadow_period_q;
    logic [CW-1:0]   shadow_refill_q;
    logic            pending_q;
    logic            bum_prev_q;
    logic            slot_start_q;
    logic [7:0]      slot_id_q;
    logic [TW-1:0]   tokens_q;
    logic [TW-1:0]   tokens_d;
    logic [CW-1:0]   pass_cnt_q;
    logic [CW-1:0]   drop_cnt_q;
    logic [DW-1:0]   out_data_q;
    logic            out_data_wr_q;
    logic            out_valid_q;
    logic            out_valid_wr_q;

    logic            toggle_c;
    logic            boundary_c;
    logic [CW:0]     sum_c;
    logic [TW-1:0]   refilled_c;
    logic [TW-1:0]   avail_c;
    logic            head_c;
    logic            tail_c;
    logic            head_pass_c;
    logic            fwd_c;
    logic [CW-1:0]   clamp_period_c;

    // Decode boundary, toggle, packet framing and the token decision for this cycle
    always_comb begin
        toggle_c       = beacon_update_master != bum_prev_q;
        boundary_c     = slot_cnt_q >= (active_period_q - CW'(1));
        sum_c          = (CW+1)'(tokens_q) + (CW+1)'(active_refill_q);
        refilled_c     = (sum_c > (CW+1)'(BUCKET_DEPTH)) ? BUCKET_DEPTH : TW'(sum_c);
        avail_c        = boundary_c ? refilled_c : tokens_q;
        head_c         = in_data_wr && (in_data[133:132] == 2'b01);
        tail_c         = in_data_wr && (in_data[133:132] == 2'b10);
        head_pass_c    = head_c && (avail_c != TW'(0));
        fwd_c          = head_c ? head_pass_c : (state_q == ST_PASS);
        clamp_period_c = (time_slot_period < CW'(2)) ? CW'(2) : time_slot_period;
        tokens_d       = avail_c;
        if (head_pass_c) begin
            tokens_d = avail_c - TW'(1);
        end
    end

    // Slot counter, boundary pulse and shadow/active configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q      <= '0;
            slot_start_q    <= 1'b0;
            slot_id_q       <= '0;
            active_period_q <= DEF_PERIOD;
            active_refill_q <= DEF_REFILL;
            shadow_period_q <= DEF_PERIOD;
            shadow_refill_q <= DEF_REFILL;
            pending_q       <= 1'b0;
            bum_prev_q      <= beacon_update_master;
        end else begin
            bum_prev_q <= beacon_update_master;
            if (boundary_c) begin
                slot_cnt_q   <= '0;
                slot_start_q <= 1'b1;
                slot_id_q    <= slot_id_q + 8'd1;
                if (pending_q) begin
                    active_period_q <= shadow_period_q;
                    active_refill_q <= shadow_refill_q;
                end
            end else begin
                slot_cnt_q   <= slot_cnt_q + CW'(1);
                slot_start_q <= 1'b0;
            end
            // A toggle on the boundary cycle is held for the following boundary
            if (toggle_c) begin
                shadow_period_q <= clamp_period_c;
                shadow_refill_q <= token_bucket_para;
                pending_q       <= 1'b1;
            end else if (boundary_c) begin
                pending_q <= 1'b0;
            end
        end
    end

    // Packet gate FSM, token bucket, counters and registered data path
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            tokens_q       <= BUCKET_DEPTH;
            pass_cnt_q     <= '0;
            drop_cnt_q     <= '0;
            out_data_q     <= '0;
            out_data_wr_q  <= 1'b0;
            out_valid_q    <= 1'b0;
            out_valid_wr_q <= 1'b0;
        end else begin
            tokens_q <= tokens_d;
            if (head_c) begin
                // A head always restarts the decision, truncating any open packet
                if (head_pass_c) begin
                    state_q    <= ST_PASS;
                    pass_cnt_q <= pass_cnt_q + CW'(1);
                end else begin
                    state_q    <= ST_DROP;
                    drop_cnt_q <= drop_cnt_q + CW'(1);
                end
            end else begin
                case (state_q)
                    ST_PASS, ST_DROP: if (tail_c) state_q <= ST_IDLE;
                    default:          state_q <= ST_IDLE;
                endcase
            end
            out_data_q     <= (fwd_c && in_data_wr) ? in_data : '0;
            out_data_wr_q  <= fwd_c && in_data_wr;
            out_valid_wr_q <= fwd_c && in_valid_wr;
            out_valid_q    <= fwd_c && in_valid_wr && in_valid;
        end
    end

    assign out_data     = out_data_q;
    assign out_data_wr  = out_data_wr_q;
    assign out_valid    = out_valid_q;
    assign out_valid_wr = out_valid_wr_q;
    assign slot_start   = slot_start_q;
    assign slot_id      = slot_id_q;
    assign tokens       = tokens_q;
    assign pass_cnt     = pass_cnt_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_slot_token_sched.sv
// Directed bench for slot_token_sched: slot timing, token bucket, deferred config, truncation.
module tb_slot_token_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  time_slot_period;
    logic [31:0]  token_bucket_para;
    logic         beacon_update_master;
    logic [133:0] in_data;
    logic         in_data_wr;
    logic         in_valid;
    logic         in_valid_wr;
    logic [133:0] out_data;
    logic         out_data_wr;
    logic         out_valid;
    logic         out_valid_wr;
    logic         slot_start;
    logic [7:0]   slot_id;
    logic [15:0]  tokens;
    logic [31:0]  pass_cnt;
    logic [31:0]  drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    slot_token_sched dut (
        .clk                  (clk),
        .rst                  (rst),
        .time_slot_period     (time_slot_period),
        .token_bucket_para    (token_bucket_para),
        .beacon_update_master (beacon_update_master),
        .in_data              (in_data),
        .in_data_wr           (in_data_wr),
        .in_valid             (in_valid),
        .in_valid_wr          (in_valid_wr),
        .out_data             (out_data),
        .out_data_wr          (out_data_wr),
        .out_valid            (out_valid),
        .out_valid_wr         (out_valid_wr),
        .slot_start           (slot_start),
        .slot_id              (slot_id),
        .tokens               (tokens),
        .pass_cnt             (pass_cnt),
        .drop_cnt             (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [133:0] mkw(input logic [1:0] t, input int k);
        logic [31:0] v;
        v = 32'hA500_0000 + 32'(k);
        return {t, 4'h0, v, v, v, v};
    endfunction

    // Drive one word at a negedge; check the registered result one cycle later
    task automatic send(input logic [1:0] t, input int k, input logic exp_pass);
        logic [133:0] w;
        logic         vw;
        w           = mkw(t, k);
        vw          = (t == 2'b10);
        in_data     = w;
        in_data_wr  = 1'b1;
        in_valid    = vw;
        in_valid_wr = vw;
        @(negedge clk);
        in_data     = '0;
        in_data_wr  = 1'b0;
        in_valid    = 1'b0;
        in_valid_wr = 1'b0;
        chk("out_data", out_data, exp_pass ? w : '0);
        chk("strobes", 134'({out_data_wr, out_valid_wr, out_valid}),
            134'({exp_pass, exp_pass & vw, exp_pass & vw}));
    endtask

    task automatic cfg(input logic [31:0] p, input logic [31:0] r);
        time_slot_period     = p;
        token_bucket_para    = r;
        beacon_update_master = ~beacon_update_master;
    endtask

    // Returns at the negedge where slot_start is seen, n = cycles waited
    task automatic wait_slot(input int budget, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (slot_start) break;
            if (n >= budget) begin
                chk("slot_timeout", 134'(0), 134'(1));
                break;
            end
        end
    endtask

    initial begin
        int pulses;
        int at;
        int n;
        int np;
        int pa [4];

        rst                  = 1'b1;
        time_slot_period     = '0;
        token_bucket_para    = '0;
        beacon_update_master = 1'b0;
        in_data              = '0;
        in_data_wr           = 1'b0;
        in_valid             = 1'b0;
        in_valid_wr          = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_tokens", 134'(tokens), 134'(64));
        chk("rst_slot_id", 134'(slot_id), 134'(0));
        chk("rst_slot_start", 134'(slot_start), 134'(0));
        chk("rst_pass", 134'(pass_cnt), 134'(0));
        chk("rst_drop", 134'(drop_cnt), 134'(0));
        chk("rst_out", out_data | 134'(out_data_wr), 134'(0));
        rst = 1'b0;

        // Default period: one pulse at 31250; config queued at cycle 10 applies there
        pulses = 0;
        at     = 0;
        for (int i = 1; i <= 31250; i++) begin
            @(negedge clk);
            if (i == 10) cfg(32'd400, 32'd10);
            if (slot_start) begin
                pulses++;
                at = i;
            end
        end
        chk("def_pulses", 134'(pulses), 134'(1));
        chk("def_pulse_at", 134'(at), 134'(31250));
        chk("def_slot_id", 134'(slot_id), 134'(1));
        chk("def_tokens", 134'(tokens), 134'(64));

        // Token exhaustion: 70 four-word packets in one 400-cycle slot
        for (int p = 0; p < 70; p++) begin
            send(2'b01, 4*p,     p < 64);
            send(2'b11, 4*p + 1, p < 64);
            send(2'b11, 4*p + 2, p < 64);
            send(2'b10, 4*p + 3, p < 64);
        end
        chk("exh_tokens", 134'(tokens), 134'(0));
        chk("exh_drop", 134'(drop_cnt), 134'(6));
        chk("exh_pass", 134'(pass_cnt), 134'(64));

        // Refill saturation from zero with refill 10, period switches to 100
        cfg(32'd100, 32'd10);
        wait_slot(200, n);
        chk("len400_rest", 134'(n), 134'(120));
        chk("refill_1", 134'(tokens), 134'(10));
        for (int k = 2; k <= 7; k++) begin
            wait_slot(200, n);
            if (k == 2) chk("len100", 134'(n), 134'(100));
            if (k == 6) chk("refill_6", 134'(tokens), 134'(60));
        end
        chk("refill_7_sat", 134'(tokens), 134'(64));

        // Head on boundary: drain with refill 0, then refill 10 arrives at a boundary
        cfg(32'd200, 32'd0);
        wait_slot(200, n);
        chk("b8_tokens", 134'(tokens), 134'(64));
        cfg(32'd200, 32'd10);
        for (int p = 0; p < 65; p++) begin
            send(2'b01, 2*p,     p < 64);
            send(2'b10, 2*p + 1, p < 64);
        end
        chk("drain_tokens", 134'(tokens), 134'(0));
        chk("drain_drop", 134'(drop_cnt), 134'(7));
        wait_slot(300, n);
        chk("b9_len", 134'(n), 134'(70));
        chk("b9_tokens", 134'(tokens), 134'(0));
        repeat (199) @(negedge clk);
        send(2'b01, 500, 1'b1);
        chk("hob_slot_start", 134'(slot_start), 134'(1));
        chk("hob_tokens", 134'(tokens), 134'(9));
        send(2'b10, 501, 1'b1);
        chk("hob_pass", 134'(pass_cnt), 134'(129));

        // Deferred config: 100, toggle mid-slot to 40, toggle on boundary to 20
        cfg(32'd100, 32'd10);
        wait_slot(300, n);
        chk("b11_len", 134'(n), 134'(199));
        np = 0;
        for (int i = 0; i < 4; i++) pa[i] = 0;
        for (int c = 1; c <= 170; c++) begin
            @(negedge clk);
            if (slot_start) begin
                if (np < 4) pa[np] = c;
                np++;
            end
            if (c == 50) cfg(32'd40, 32'd10);
            if (c == 99) cfg(32'd20, 32'd10);
        end
        chk("def_npulses", 134'(np), 134'(3));
        chk("def_slot_100", 134'(pa[0]), 134'(100));
        chk("def_slot_40", 134'(pa[1] - pa[0]), 134'(40));
        chk("def_slot_20", 134'(pa[2] - pa[1]), 134'(20));

        // Truncated packet: new head before the tail restarts the decision
        send(2'b01, 1000, 1'b1);
        send(2'b11, 1001, 1'b1);
        send(2'b01, 1002, 1'b1);
        send(2'b10, 1003, 1'b1);
        chk("trunc_pass", 134'(pass_cnt), 134'(131));

        // Period below 2 is clamped to 2
        cfg(32'd0, 32'd10);
        wait_slot(50, n);
        wait_slot(50, n);
        chk("clamp_len", 134'(n), 134'(2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
